// File: rtl/mc14500b_trace_uart.sv
// mc14500b_trace_uart: captures every change of the MC14500B TRACE byte
// into a small circular FIFO and drains it as back-to-back 8N1 UART frames.
module mc14500b_trace_uart #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic [7:0]                    TRACE,
    output logic                          TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FILL,
    output logic                          OVERFLOW
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FILL_FULL  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Capture / FIFO state
    logic [7:0]    prev_q, prev_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   fill_q, fill_d;
    logic          overflow_q, overflow_d;

    // Transmitter state
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;

    logic push;
    logic pop;
    logic wr_en;
    logic fifo_empty;
    logic fifo_full;
    logic bit_done;

    assign push       = EN && (TRACE != prev_q);
    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_FULL);
    assign bit_done   = (cnt_q == '0);

    // Transmitter next-state: decides the pop and the TX level for the next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    cnt_d   = BIT_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = BIT_RELOAD;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shreg_q[idx_q];
                if (bit_done) begin
                    cnt_d = BIT_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        cnt_d   = BIT_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a push into a full queue survives only if a pop frees the slot
    always_comb begin
        prev_d     = TRACE;
        wr_en      = push && (!fifo_full || pop);
        overflow_d = overflow_q | (push && fifo_full && !pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d     = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Queue storage; contents need no reset because the pointers and fill define validity
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= TRACE;
        end
    end

    // State registers; reset drops all queued data and forces TX high at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign TX       = tx_q;
    assign FILL     = fill_q;
    assign OVERFLOW = overflow_q;
    assign BUSY     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mc14500b_trace_uart.sv
// tb_mc14500b_trace_uart: directed bench for the trace UART with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Every output is logged once per cycle
// on the falling clock edge, and the logged waveform is compared against
// hand-derived frame timing.
module tb_mc14500b_trace_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int LOGN  = 256;

    logic       clock;
    logic       resetN;
    logic       enable;
    logic [7:0] trace;
    logic       tx;
    logic       busy;
    logic [2:0] fill;
    logic       overflow;

    int compared;
    int mismatched;

    // Per-cycle sample log; index i holds the values seen after the (i+1)-th rising edge
    logic       txLog   [0:LOGN-1];
    logic       busyLog [0:LOGN-1];
    logic [2:0] fillLog [0:LOGN-1];
    logic       ovfLog  [0:LOGN-1];
    int         idx;

    logic [7:0] expBytes [0:7];

    mc14500b_trace_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK     (clock),
        .RST     (resetN),
        .EN      (enable),
        .TRACE   (trace),
        .TX      (tx),
        .BUSY    (busy),
        .FILL    (fill),
        .OVERFLOW(overflow)
    );

    // Free-running 10-time-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it, and on a miss counts the failure and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and record every output there
    task automatic tick();
        @(negedge clock);
        if (idx < LOGN) begin
            txLog[idx]   = tx;
            busyLog[idx] = busy;
            fillLog[idx] = fill;
            ovfLog[idx]  = overflow;
            idx++;
        end
    endtask

    // Drive EN/TRACE right after a falling edge, then run a number of cycles
    task automatic applyStimulus(input logic en, input logic [7:0] value, input int cycles);
        enable = en;
        trace  = value;
        for (int c = 0; c < cycles; c++) begin
            tick();
        end
    endtask

    // Ideal TX level at log index i for n contiguous frames starting at index s
    function automatic logic expTx(input int i, input int s, input int n);
        int j;
        int f;
        int b;
        logic [7:0] byteVal;
        if (i < s) return 1'b1;
        j = i - s;
        f = j / FRAME;
        if (f >= n) return 1'b1;
        b = (j % FRAME) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        byteVal = expBytes[f];
        return byteVal[b-1];
    endfunction

    // Whole-waveform comparison over the first len logged samples
    task automatic checkWave(input string tag, input int s, input int n, input int len);
        int bad;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (txLog[i] !== expTx(i, s, n)) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    // Decode each frame from mid-bit samples and compare to the expected byte
    task automatic decodeFrames(input string tag, input int s, input int n);
        logic [7:0] d;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < 8; b++) begin
                d[b] = txLog[s + f*FRAME + (b+1)*CPB + 1];
            end
            checkOutput($sformatf("%s_byte%0d", tag, f), {24'h0, d}, {24'h0, expBytes[f]});
        end
    endtask

    function automatic int firstLow(input int len);
        for (int i = 0; i < len; i++) begin
            if (txLog[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int maxFill(input int len);
        int m;
        m = 0;
        for (int i = 0; i < len; i++) begin
            if (int'(fillLog[i]) > m) m = int'(fillLog[i]);
        end
        return m;
    endfunction

    // Counts samples where the block was not quietly idle
    function automatic int idleViolations(input int len);
        int bad;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (txLog[i] !== 1'b1 || busyLog[i] !== 1'b0 || fillLog[i] !== 3'd0) bad++;
        end
        return bad;
    endfunction

    // Directed scenario sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        idx        = 0;
        resetN     = 1'b0;
        enable     = 1'b1;
        trace      = 8'h00;

        $display("[TB] reset and idle hold");
        repeat (3) @(negedge clock);
        checkOutput("rst_tx", {31'h0, tx}, 1);
        checkOutput("rst_busy", {31'h0, busy}, 0);
        checkOutput("rst_fill", {29'h0, fill}, 0);
        checkOutput("rst_ovf", {31'h0, overflow}, 0);
        resetN = 1'b1;
        idx = 0;
        applyStimulus(1'b1, 8'h00, 100);
        checkOutput("idle_hold", idleViolations(100), 0);

        $display("[TB] single step to 0xA5");
        idx = 0;
        expBytes[0] = 8'hA5;
        applyStimulus(1'b1, 8'hA5, 60);
        checkOutput("a5_fill_at_k", {29'h0, fillLog[0]}, 1);
        checkOutput("a5_fill_after_pop", {29'h0, fillLog[1]}, 0);
        checkOutput("a5_fall_delay", firstLow(60), 2);
        checkWave("a5_wave", 2, 1, 60);
        decodeFrames("a5", 2, 1);
        checkOutput("a5_busy_last", {31'h0, busyLog[40]}, 1);
        checkOutput("a5_busy_drop", {31'h0, busyLog[41]}, 0);

        $display("[TB] three-byte burst");
        idx = 0;
        expBytes[0] = 8'h01;
        expBytes[1] = 8'h02;
        expBytes[2] = 8'h03;
        applyStimulus(1'b1, 8'h01, 1);
        applyStimulus(1'b1, 8'h02, 1);
        applyStimulus(1'b1, 8'h03, 130);
        checkOutput("burst_fill_peak", maxFill(132), 2);
        checkOutput("burst_fall_delay", firstLow(132), 2);
        checkWave("burst_wave", 2, 3, 132);
        decodeFrames("burst", 2, 3);
        checkOutput("burst_busy_last", {31'h0, busyLog[120]}, 1);
        checkOutput("burst_busy_drop", {31'h0, busyLog[121]}, 0);

        $display("[TB] six-byte burst into a four-entry queue");
        idx = 0;
        for (int v = 0; v < 5; v++) begin
            expBytes[v] = 8'h11 + 8'(v);
        end
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b1, 8'h11 + 8'(v), 1);
        end
        applyStimulus(1'b1, 8'h16, 210);
        checkOutput("ovf_before_drop", {31'h0, ovfLog[4]}, 0);
        checkOutput("ovf_at_drop", {31'h0, ovfLog[5]}, 1);
        checkOutput("ovf_fill_full", {29'h0, fillLog[4]}, 4);
        checkOutput("ovf_fill_held", {29'h0, fillLog[5]}, 4);
        checkOutput("ovf_fill_peak", maxFill(216), 4);
        checkWave("ovf_wave", 2, 5, 216);
        decodeFrames("ovf", 2, 5);
        checkOutput("ovf_sticky", {31'h0, ovfLog[215]}, 1);
        checkOutput("ovf_busy_end", {31'h0, busyLog[215]}, 0);

        $display("[TB] capture disabled while TRACE toggles");
        idx = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, (i % 2 == 1) ? 8'h20 : 8'h10, 1);
        end
        applyStimulus(1'b1, 8'h20, 60);
        checkOutput("en_off_idle", idleViolations(110), 0);
        checkOutput("en_off_ovf_kept", {31'h0, ovfLog[109]}, 1);

        $display("[TB] reset during DATA bit 3");
        idx = 0;
        applyStimulus(1'b1, 8'h35, 1);
        applyStimulus(1'b1, 8'h36, 1);
        applyStimulus(1'b1, 8'h37, 17);
        checkOutput("mid_tx_bit2", {31'h0, txLog[17]}, 1);
        checkOutput("mid_tx_bit3", {31'h0, txLog[18]}, 0);
        checkOutput("mid_fill", {29'h0, fillLog[18]}, 2);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("mid_rst_tx", {31'h0, tx}, 1);
        checkOutput("mid_rst_fill", {29'h0, fill}, 0);
        checkOutput("mid_rst_busy", {31'h0, busy}, 0);
        trace = 8'h00;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        idx = 0;
        applyStimulus(1'b1, 8'h00, 60);
        checkOutput("post_rst_idle", idleViolations(60), 0);
        checkOutput("post_rst_ovf", {31'h0, ovfLog[59]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
